// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: display fetch > screen clear > buffered pixel writes.
// Optional stall counter output enabled by defining VRAM_ARB_STALL_CNT_EN.
module vram_arbiter #(
    parameter int ADDR_W     = 17,
    parameter int DEPTH      = 76800,
    parameter int WFIFO_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              fetch_req,
    output logic [7:0]        pix_data,
    output logic              pix_valid,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              clr_req,
    input  logic [7:0]        clr_color,
    output logic              clr_busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
`ifdef VRAM_ARB_STALL_CNT_EN
    output logic [15:0]       stall_cnt,
`endif
    output logic              o_dbg_state
);

    typedef enum logic {ST_RUN = 1'b0, ST_CLEAR = 1'b1} state_t;

    localparam int                FIFO_DEPTH = 1 << WFIFO_LOG2;
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_disp_addr;
    logic [ADDR_W-1:0]   r_clr_addr;
    logic [7:0]          r_clr_color;
    logic                r_ready_en;
    logic                r_rd_p1;
    logic                r_rd_p2;
    logic [WFIFO_LOG2:0] r_wptr;
    logic [WFIFO_LOG2:0] r_rptr;
    logic [ADDR_W-1:0]   r_fifo_addr [FIFO_DEPTH];
    logic [7:0]          r_fifo_data [FIFO_DEPTH];

    logic                w_empty;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic [ADDR_W-1:0]   w_fetch_addr;

    // Writer handshake: a pixel transfers on any rising edge where wr_valid && wr_ready.
    // wr_ready is low while the FIFO is full and during reset, so a full FIFO never
    // sees a push and pop in the same cycle. wr_valid may be dropped at any time.
    assign w_empty      = (r_wptr == r_rptr);
    assign w_full       = (r_wptr[WFIFO_LOG2] != r_rptr[WFIFO_LOG2]) &&
                          (r_wptr[WFIFO_LOG2-1:0] == r_rptr[WFIFO_LOG2-1:0]);
    assign wr_ready     = r_ready_en && !w_full;
    assign w_push       = wr_valid && wr_ready;
    assign w_pop        = !fetch_req && (r_state == ST_RUN) && !w_empty;
    assign w_fetch_addr = frame_start ? '0 : r_disp_addr;
    assign clr_busy     = (r_state == ST_CLEAR);
    assign o_dbg_state  = r_state;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wptr[WFIFO_LOG2-1:0]] <= wr_addr;
            r_fifo_data[r_wptr[WFIFO_LOG2-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_disp_addr <= '0;
            r_clr_addr  <= '0;
            r_clr_color <= '0;
            r_ready_en  <= 1'b0;
            r_rd_p1     <= 1'b0;
            r_rd_p2     <= 1'b0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            pix_data    <= '0;
            pix_valid   <= 1'b0;
            mem_addr    <= '0;
            mem_we      <= 1'b0;
            mem_wdata   <= '0;
        end else begin
            r_ready_en <= 1'b1;
            mem_we     <= 1'b0;

            if (fetch_req) begin
                mem_addr <= w_fetch_addr;
            end else if (r_state == ST_CLEAR) begin
                mem_addr  <= r_clr_addr;
                mem_we    <= 1'b1;
                mem_wdata <= r_clr_color;
            end else if (!w_empty) begin
                mem_addr  <= r_fifo_addr[r_rptr[WFIFO_LOG2-1:0]];
                mem_we    <= 1'b1;
                mem_wdata <= r_fifo_data[r_rptr[WFIFO_LOG2-1:0]];
            end

            if (fetch_req)
                r_disp_addr <= (w_fetch_addr == LAST_ADDR) ? '0 : w_fetch_addr + 1'b1;
            else if (frame_start)
                r_disp_addr <= '0;

            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;

            // Read data arrives one cycle after the address; register it a cycle later.
            r_rd_p1   <= fetch_req;
            r_rd_p2   <= r_rd_p1;
            pix_valid <= r_rd_p2;
            if (r_rd_p2) pix_data <= mem_rdata;

            case (r_state)
                ST_RUN: begin
                    if (clr_req) begin
                        r_state     <= ST_CLEAR;
                        r_clr_addr  <= '0;
                        r_clr_color <= clr_color;
                    end
                end
                ST_CLEAR: begin
                    if (!fetch_req) begin
                        if (r_clr_addr == LAST_ADDR) begin
                            r_state    <= ST_RUN;
                            r_clr_addr <= '0;
                        end else begin
                            r_clr_addr <= r_clr_addr + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

`ifdef VRAM_ARB_STALL_CNT_EN
    // Counts cycles where a queued write is held off by a fetch or a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (frame_start)
            stall_cnt <= '0;
        else if (!w_empty && !w_pop && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter (DEPTH=16) with a registered-read RAM model.
// Covers the stall counter when VRAM_ARB_STALL_CNT_EN is defined.
module tb_vram_arbiter;

  localparam int ADDR_W = 17;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              frame_start;
  logic              fetch_req;
  logic [7:0]        pix_data;
  logic              pix_valid;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              clr_req;
  logic [7:0]        clr_color;
  logic              clr_busy;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              o_dbg_state;
`ifdef VRAM_ARB_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] ram [0:255];
  logic       ram_init;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'(i);
    end else if (mem_we) begin
      ram[mem_addr[7:0]] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr[7:0]];
  end

  vram_arbiter #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .WFIFO_LOG2(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .frame_start(frame_start),
    .fetch_req(fetch_req),
    .pix_data(pix_data),
    .pix_valid(pix_valid),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .clr_req(clr_req),
    .clr_color(clr_color),
    .clr_busy(clr_busy),
    .mem_addr(mem_addr),
    .mem_we(mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
`ifdef VRAM_ARB_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .o_dbg_state(o_dbg_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ram_init = 1'b1;
    repeat (3) tick();
    ram_init = 1'b0;
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL reset_pix_valid got %0b want 0", pix_valid); end
    checks++; if (pix_data !== 8'h00) begin errors++; $display("FAIL reset_pix_data got %0h want 0", pix_data); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %0b want 0", mem_we); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr got %0h want 0", mem_addr); end
    checks++; if (mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_mem_wdata got %0h want 0", mem_wdata); end
    checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL reset_clr_busy got %0b want 0", clr_busy); end
    checks++; if (o_dbg_state !== 1'b0) begin errors++; $display("FAIL reset_state got %0b want 0", o_dbg_state); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready got %0b want 0", wr_ready); end
`ifdef VRAM_ARB_STALL_CNT_EN
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
`endif
    #2 rst_n = 1'b1;
    #1;
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL release_wr_ready_early got %0b want 0", wr_ready); end
    tick();
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL release_wr_ready got %0b want 1", wr_ready); end
  endtask

  task automatic test_fetch();
    logic exp_v;
    for (int k = 0; k < 7; k++) begin
      fetch_req = (k < 4);
      frame_start = (k == 0);
      tick();
      frame_start = 1'b0;
      if (k < 4) begin
        checks++;
        if (mem_addr !== ADDR_W'(k) || mem_we !== 1'b0) begin
          errors++; $display("FAIL fetch_addr k=%0d got addr %0d we %0b want addr %0d we 0", k, mem_addr, mem_we, k);
        end
      end
      exp_v = (k >= 2 && k <= 5);
      checks++;
      if (pix_valid !== exp_v) begin errors++; $display("FAIL fetch_pix_valid k=%0d got %0b want %0b", k, pix_valid, exp_v); end
      if (exp_v) begin
        checks++;
        if (pix_data !== 8'(k - 2)) begin errors++; $display("FAIL fetch_pix_data k=%0d got %0h want %0h", k, pix_data, 8'(k - 2)); end
      end
    end
    fetch_req = 1'b0;
  endtask

  task automatic test_single_write();
    logic found;
    fetch_req = 1'b0;
    wr_valid = 1'b1; wr_addr = ADDR_W'(5); wr_data = 8'hA5;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL wr_ready_idle got %0b want 1", wr_ready); end
    tick();
    wr_valid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (!found) begin
        tick();
        if (mem_we === 1'b1) found = 1'b1;
      end
    end
    checks++;
    if (!found || mem_addr !== ADDR_W'(5) || mem_wdata !== 8'hA5) begin
      errors++; $display("FAIL single_write got found %0b addr %0h data %0h want 1 5 a5", found, mem_addr, mem_wdata);
    end
    tick();
    checks++;
    if (mem_we !== 1'b0 || mem_addr !== ADDR_W'(5)) begin
      errors++; $display("FAIL idle_hold got we %0b addr %0h want we 0 addr 5", mem_we, mem_addr);
    end
  endtask

  task automatic test_fifo_full();
    logic [ADDR_W+7:0] exp_q[$];
    logic [ADDR_W+7:0] exp_e;
    logic              exp_rdy;
    fetch_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1;
      wr_addr  = ADDR_W'(8 + i);
      wr_data  = 8'h10 + 8'(i);
      exp_rdy  = (i < 4);
      checks++;
      if (wr_ready !== exp_rdy) begin errors++; $display("FAIL full_wr_ready i=%0d got %0b want %0b", i, wr_ready, exp_rdy); end
      if (exp_rdy) exp_q.push_back({ADDR_W'(8 + i), 8'h10 + 8'(i)});
      tick();
      checks++;
      if (mem_we !== 1'b0) begin errors++; $display("FAIL full_no_we i=%0d got %0b want 0", i, mem_we); end
    end
    wr_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (mem_we !== 1'b0) begin errors++; $display("FAIL full_hold_no_we i=%0d got %0b want 0", i, mem_we); end
    end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_wr_ready_low got %0b want 0", wr_ready); end
    fetch_req = 1'b0;
    for (int j = 0; j < 4; j++) begin
      tick();
      exp_e = exp_q.pop_front();
      checks++;
      if (mem_we !== 1'b1 || {mem_addr, mem_wdata} !== exp_e) begin
        errors++; $display("FAIL drain j=%0d got we %0b addr %0h data %0h want we 1 addr %0h data %0h",
                           j, mem_we, mem_addr, mem_wdata, exp_e[ADDR_W+7:8], exp_e[7:0]);
      end
    end
    tick();
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL drain_done_we got %0b want 0", mem_we); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL drain_wr_ready got %0b want 1", wr_ready); end
  endtask

  task automatic test_clear();
    int   clr_exp;
    logic done;
    fetch_req = 1'b0; clr_color = 8'h3C; clr_req = 1'b1;
    tick();
    clr_req = 1'b0; clr_color = 8'hFF;
    checks++;
    if (clr_busy !== 1'b1 || o_dbg_state !== 1'b1) begin
      errors++; $display("FAIL clear_entry got busy %0b state %0b want 1 1", clr_busy, o_dbg_state);
    end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL clear_entry_we got %0b want 0", mem_we); end
    clr_exp = 0; done = 1'b0;
    wr_addr = ADDR_W'(20); wr_data = 8'h77;
    for (int k = 0; k < 40; k++) begin
      if (!done) begin
        fetch_req = (k % 2 == 0);
        clr_req   = (k == 3);
        wr_valid  = (k == 0);
        tick();
        if (fetch_req) begin
          checks++;
          if (mem_we !== 1'b0) begin errors++; $display("FAIL clear_fetch_no_we k=%0d got %0b want 0", k, mem_we); end
        end else begin
          checks++;
          if (mem_we !== 1'b1 || mem_addr !== ADDR_W'(clr_exp) || mem_wdata !== 8'h3C) begin
            errors++; $display("FAIL clear_write k=%0d got we %0b addr %0d data %0h want 1 %0d 3c", k, mem_we, mem_addr, mem_wdata, clr_exp);
          end
          checks++;
          if (clr_busy !== (clr_exp != DEPTH - 1)) begin
            errors++; $display("FAIL clear_busy addr=%0d got %0b want %0b", clr_exp, clr_busy, (clr_exp != DEPTH - 1));
          end
          if (clr_exp == DEPTH - 1) done = 1'b1;
          clr_exp++;
        end
      end
    end
    clr_req = 1'b0; wr_valid = 1'b0; fetch_req = 1'b0;
    checks++;
    if (!done || clr_exp != DEPTH) begin errors++; $display("FAIL clear_timeout got %0d writes want %0d", clr_exp, DEPTH); end
    tick();
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== ADDR_W'(20) || mem_wdata !== 8'h77) begin
      errors++; $display("FAIL clear_resume got we %0b addr %0d data %0h want 1 20 77", mem_we, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_wrap();
    fetch_req = 1'b0; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int k = 0; k < 17; k++) begin
      fetch_req = 1'b1;
      tick();
      checks++;
      if (mem_addr !== ADDR_W'(k % DEPTH)) begin errors++; $display("FAIL wrap_addr k=%0d got %0d want %0d", k, mem_addr, k % DEPTH); end
    end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL frame_start_prio got %0d want 0", mem_addr); end
    tick();
    checks++; if (mem_addr !== ADDR_W'(1)) begin errors++; $display("FAIL after_frame_start got %0d want 1", mem_addr); end
    fetch_req = 1'b0;
  endtask

  task automatic test_reset_mid_clear();
    clr_color = 8'h5A; clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (3) tick();
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (clr_busy !== 1'b0 || mem_we !== 1'b0 || wr_ready !== 1'b0 || mem_addr !== '0) begin
      errors++; $display("FAIL async_reset got busy %0b we %0b rdy %0b addr %0d want 0 0 0 0", clr_busy, mem_we, wr_ready, mem_addr);
    end
    repeat (2) tick();
    #2 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (mem_we !== 1'b0 || clr_busy !== 1'b0 || pix_valid !== 1'b0) begin
        errors++; $display("FAIL post_reset k=%0d got we %0b busy %0b pv %0b want 0 0 0", k, mem_we, clr_busy, pix_valid);
      end
    end
  endtask

`ifdef VRAM_ARB_STALL_CNT_EN
  task automatic test_stall();
    fetch_req = 1'b1;
    wr_valid = 1'b1; wr_addr = ADDR_W'(30); wr_data = 8'h99;
    tick();
    wr_valid = 1'b0;
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL stall_start got %0d want 0", stall_cnt); end
    repeat (10) tick();
    checks++; if (stall_cnt !== 16'd10) begin errors++; $display("FAIL stall_ten got %0d want 10", stall_cnt); end
    fetch_req = 1'b0;
    tick();
    checks++;
    if (stall_cnt !== 16'd10 || mem_we !== 1'b1 || mem_addr !== ADDR_W'(30)) begin
      errors++; $display("FAIL stall_pop got cnt %0d we %0b addr %0d want 10 1 30", stall_cnt, mem_we, mem_addr);
    end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL stall_clear got %0d want 0", stall_cnt); end
  endtask
`endif

  initial begin
    rst_n = 1'b0; ram_init = 1'b1;
    frame_start = 1'b0; fetch_req = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    clr_req = 1'b0; clr_color = '0;
    test_reset();
    test_fetch();
    test_single_write();
    test_fifo_full();
    test_clear();
    test_wrap();
    test_reset_mid_clear();
`ifdef VRAM_ARB_STALL_CNT_EN
    test_stall();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter ADDR_W, 17, video RAM address width.
REQ-002 Parameter DEPTH, 76800, number of addressable pixels; display address wraps at DEPTH-1.
REQ-003 Parameter WFIFO_LOG2, 2, log2 of the write FIFO depth (4 entries).
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 frame_start  in  1  one-cycle pulse; resets display read address to 0.
REQ-007 fetch_req  in  1  display pixel fetch request, one read per asserted cycle.
REQ-008 pix_data  out  8  fetched pixel; pix_valid  out  1  qualifies pix_data.
REQ-009 wr_valid  in  1; wr_ready  out  1; wr_addr  in  ADDR_W; wr_data  in  8: pixel-writer handshake.
REQ-010 clr_req  in  1  pulse starting a full-screen clear; clr_color  in  8; clr_busy  out  1.
REQ-011 mem_addr  out  ADDR_W; mem_we  out  1; mem_wdata  out  8: registered single-port RAM controls; mem_rdata  in  8, valid one cycle after the read address is presented.

Function
REQ-012 Exactly one RAM operation per cycle; priority: display fetch > clear write > FIFO write.
REQ-013 A fetch_req sampled at edge N drives mem_addr=display address and mem_we=0 after edge N; pix_valid=1 with the data after edge N+2 (latency 3 cycles, full throughput).
REQ-014 Display address increments by 1 per accepted fetch, wraps DEPTH-1 -> 0; frame_start has priority over a simultaneous increment and yields address 0 for that cycle's fetch.
REQ-015 Write transfer occurs when wr_valid && wr_ready; wr_ready = FIFO not full; FIFO is FIFO-ordered, simultaneous push and pop when full is disallowed by wr_ready=0.
REQ-016 FIFO entry pops, and issues mem_we=1 with its addr/data, only in a cycle with no fetch and FSM in RUN.
REQ-017 FSM states RUN and CLEAR; RUN -> CLEAR on clr_req (clear address loaded 0, clr_color latched); CLEAR -> RUN after the write to address DEPTH-1 is issued.
REQ-018 In CLEAR: clr_busy=1, clear address advances only on cycles with no fetch, FIFO does not pop but still accepts writes until full.
REQ-019 clr_req while in CLEAR is ignored; clr_color changes after entry have no effect.
REQ-020 mem_we=0 and mem_addr holds its previous value on idle cycles.

Reset
REQ-021 On rst_n=0, immediately: FSM=RUN, FIFO empty, display and clear addresses 0, pix_data=0, pix_valid=0, mem_we=0, mem_addr=0, mem_wdata=0, clr_busy=0, wr_ready=0.
REQ-022 wr_ready rises one cycle after rst_n deasserts; in-flight fetches and clears are discarded.

Configuration
REQ-023 With VRAM_ARB_STALL_CNT_EN defined: output stall_cnt (16 bits) counts cycles where the FIFO is non-empty but cannot pop, saturating at 16'hFFFF, reset 0, cleared on frame_start.
REQ-024 Without VRAM_ARB_STALL_CNT_EN: no stall_cnt port and no counter logic; all other behaviour identical.

Verification
REQ-025 After reset, write addr 5 data 8'hA5 with fetch_req=0 -> mem_we=1, mem_addr=5, mem_wdata=8'hA5 within 3 cycles.
REQ-026 frame_start, then 4 consecutive fetch_req with RAM preloaded addr i = i -> pix_valid for 4 cycles starting 3 cycles later, pix_data 0,1,2,3.
REQ-027 fetch_req held high, 5 writes offered -> 4 accepted, wr_ready=0, no mem_we until fetch_req drops, then 4 writes in order.
REQ-028 DEPTH=16, clr_req with clr_color 8'h3C and alternating fetch_req -> 16 clear writes of 8'h3C, clr_busy drops after address 15, FIFO writes resume.
REQ-029 Fetch at address DEPTH-1 then fetch -> second read address 0; rst_n low mid-CLEAR -> clr_busy=0 immediately, no further mem_we.
REQ-030 With VRAM_ARB_STALL_CNT_EN, 1 queued write and fetch_req high 10 cycles -> stall_cnt=10; frame_start -> 0.
